// File: rtl/axis_axi_write_master_pkg.sv
// Shared AXI encodings, the 4 KB burst boundary and the write-master state encoding.
// Shared by the write master and its burst-size helper.
package axis_axi_write_master_pkg;

  localparam logic [1:0]  AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR   = 2'b10;
  localparam logic [3:0]  AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [12:0] AXI_4K_BYTES      = 13'd4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AW     = 2'd1,
    ST_W_DATA = 2'd2,
    ST_W_RESP = 2'd3
  } wm_state_t;

  function automatic logic [12:0] min13(input logic [12:0] a, input logic [12:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// Beats for the next INCR burst: min(remaining, MAX_BURST_LEN, words to the next 4 KB line).
// Purely combinational so a read master can reuse it unchanged.
module axi_burst_calc
  import axis_axi_write_master_pkg::*;
#(
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST_LEN = 256,
  parameter int SIZE_LOG2     = 2
) (
  input  logic [11:0]          i_addr_lo,
  input  logic [LEN_WIDTH-1:0] i_remaining,
  output logic [8:0]           o_beats,
  output logic [7:0]           o_awlen
);

  localparam int RW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  logic [RW-1:0] w_rem_wide;
  logic [12:0]   w_rem;
  logic [12:0]   w_to_4k;
  logic [12:0]   w_max;
  logic [12:0]   w_beats;

  // Clamp remaining to 4096 first; no burst can exceed that anyway.
  assign w_rem_wide = RW'(i_remaining);
  assign w_rem      = (w_rem_wide > RW'(4096)) ? 13'd4096 : w_rem_wide[12:0];
  assign w_to_4k    = (AXI_4K_BYTES - {1'b0, i_addr_lo}) >> SIZE_LOG2;
  assign w_max      = 13'(MAX_BURST_LEN);
  assign w_beats    = min13(min13(w_rem, w_max), w_to_4k);

  assign o_beats = w_beats[8:0];
  assign o_awlen = 8'(w_beats - 13'd1);

endmodule

// File: rtl/axis_axi_write_master.sv
// AXI-Stream to AXI4 write DMA: splits a (address, word count) command into INCR bursts
// that never cross 4 KB, streams s_axis onto W, and reports completion with an error flag.
module axis_axi_write_master
  import axis_axi_write_master_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int ID_WIDTH      = 8,
  parameter int AXI_ID        = 0,
  parameter int MAX_BURST_LEN = 256,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    busy,
  output logic                    status_valid,
  output logic                    status_error,
  output logic [1:0]              dbg_state
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);

  // Every channel moves one item on a rising edge where its valid and ready are both high;
  // a source never drops valid or changes payload until that edge.

  wm_state_t             r_state;
  wm_state_t             w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [8:0]            r_beats;
  logic [7:0]            r_awlen;
  logic [7:0]            r_beat_cnt;
  logic                  r_awvalid;
  logic                  r_error;
  logic                  r_status_valid;
  logic                  r_status_error;

  logic                  w_in_idle;
  logic                  w_in_wdata;
  logic                  w_in_wresp;
  logic                  w_cmd_fire;
  logic                  w_aw_fire;
  logic                  w_w_fire;
  logic                  w_b_fire;
  logic                  w_last_beat;
  logic                  w_resp_err;
  logic [8:0]            w_calc_beats;
  logic [7:0]            w_calc_awlen;
  logic [ADDR_WIDTH-1:0] w_addr_aligned;
  logic [ADDR_WIDTH-1:0] w_burst_bytes;

  axi_burst_calc #(
    .LEN_WIDTH     (LEN_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN),
    .SIZE_LOG2     (SIZE_LOG2)
  ) u_burst_calc (
    .i_addr_lo   (r_addr[11:0]),
    .i_remaining (r_remaining),
    .o_beats     (w_calc_beats),
    .o_awlen     (w_calc_awlen)
  );

  assign w_addr_aligned = cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
  assign w_burst_bytes  = ADDR_WIDTH'({23'd0, r_beats} << SIZE_LOG2);
  assign w_resp_err     = (m_axi_bresp & AXI_RESP_SLVERR) != AXI_RESP_OKAY;

  assign w_cmd_fire  = w_in_idle && cmd_valid;
  assign w_aw_fire   = (r_state == ST_AW) && r_awvalid && m_axi_awready;
  assign w_w_fire    = w_in_wdata && s_axis_tvalid && m_axi_wready;
  assign w_b_fire    = w_in_wresp && m_axi_bvalid;
  assign w_last_beat = (r_beat_cnt == r_awlen);

  always_comb begin
    w_state_next = r_state;
    w_in_idle    = 1'b0;
    w_in_wdata   = 1'b0;
    w_in_wresp   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_idle = 1'b1;
        if (cmd_valid && (cmd_len != '0)) w_state_next = ST_AW;
      end
      ST_AW: begin
        if (r_awvalid && m_axi_awready) w_state_next = ST_W_DATA;
      end
      ST_W_DATA: begin
        w_in_wdata = 1'b1;
        if (s_axis_tvalid && m_axi_wready && w_last_beat) w_state_next = ST_W_RESP;
      end
      ST_W_RESP: begin
        w_in_wresp = 1'b1;
        if (m_axi_bvalid) w_state_next = (r_remaining != '0) ? ST_AW : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr         <= '0;
      r_remaining    <= '0;
      r_beats        <= '0;
      r_awlen        <= '0;
      r_beat_cnt     <= '0;
      r_awvalid      <= 1'b0;
      r_error        <= 1'b0;
      r_status_valid <= 1'b0;
      r_status_error <= 1'b0;
    end else begin
      r_status_valid <= 1'b0;
      if (w_cmd_fire) begin
        r_addr      <= w_addr_aligned;
        r_remaining <= cmd_len;
        r_error     <= 1'b0;
        if (cmd_len == '0) begin
          r_status_valid <= 1'b1;
          r_status_error <= 1'b0;
        end else begin
          r_awvalid <= 1'b1;
        end
      end
      // Burst size is frozen at the AW handshake; W beats count against it.
      if (w_aw_fire) begin
        r_awvalid  <= 1'b0;
        r_beats    <= w_calc_beats;
        r_awlen    <= w_calc_awlen;
        r_beat_cnt <= '0;
      end
      if (w_w_fire) begin
        if (w_last_beat) begin
          r_addr      <= r_addr + w_burst_bytes;
          r_remaining <= r_remaining - LEN_WIDTH'(r_beats);
        end else begin
          r_beat_cnt <= r_beat_cnt + 8'd1;
        end
      end
      if (w_b_fire) begin
        r_error <= r_error | w_resp_err;
        if (r_remaining != '0) begin
          r_awvalid <= 1'b1;
        end else begin
          r_status_valid <= 1'b1;
          r_status_error <= r_error | w_resp_err;
        end
      end
    end
  end

  assign cmd_ready     = w_in_idle && rst_n;
  assign s_axis_tready = w_in_wdata && m_axi_wready;

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = w_calc_awlen;
  assign m_axi_awsize  = 3'(SIZE_LOG2);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_DEFAULT;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;

  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = w_in_wdata && w_last_beat;
  assign m_axi_wvalid  = w_in_wdata && s_axis_tvalid;
  assign m_axi_bready  = w_in_wresp;

  assign busy          = (r_state != ST_IDLE);
  assign status_valid  = r_status_valid;
  assign status_error  = r_status_error;
  assign dbg_state     = r_state;

endmodule
